// File: rtl/episode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : episode_sequencer
//  Description : Runs Q-learning episodes (load, observe, act, step, reward,
//                update) against the 4-lane traffic environment.
//  Revision    : 1.0  initial release
// ============================================================================
module episode_sequencer #(
    parameter int          N_STEP    = 16,
    parameter int          N_EPISODE = 100,
    parameter logic [7:0]  EPS       = 8'd26,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [11:0] S,
    input  logic        act_valid,
    input  logic [1:0]  act_in,
    input  logic        upd_done,
    output logic        env_load,
    output logic        env_step,
    output logic [1:0]  A,
    output logic        learning,
    output logic        state_valid,
    output logic [11:0] state_out,
    output logic        explore,
    output logic [5:0]  reward,
    output logic        upd_req,
    output logic [7:0]  step_cnt,
    output logic [7:0]  episode_cnt,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LOAD    = 4'd1;
    localparam logic [3:0] ST_OBSERVE = 4'd2;
    localparam logic [3:0] ST_STEP    = 4'd3;
    localparam logic [3:0] ST_SETTLE  = 4'd4;
    localparam logic [3:0] ST_REWARD  = 4'd5;
    localparam logic [3:0] ST_UPDATE  = 4'd6;
    localparam logic [3:0] ST_NEXT    = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    localparam logic [7:0] LAST_STEP    = 8'(N_STEP - 1);
    localparam logic [7:0] LAST_EPISODE = 8'(N_EPISODE - 1);

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        rand_pick;
    logic        aborting;
    logic [5:0]  queue_sum;

    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign rand_pick = (lfsr[7:0] < EPS);
    assign aborting  = abort && (state != ST_IDLE);
    assign queue_sum = 6'(S[2:0]) + 6'(S[5:3]) + 6'(S[8:6]) + 6'(S[11:9]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (aborting) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nxt = ST_LOAD;
                ST_LOAD:    state_nxt = ST_OBSERVE;
                ST_OBSERVE: if (act_valid) state_nxt = ST_STEP;
                ST_STEP:    state_nxt = ST_SETTLE;
                ST_SETTLE:  state_nxt = ST_REWARD;
                ST_REWARD:  state_nxt = ST_UPDATE;
                ST_UPDATE:  if (upd_done) state_nxt = ST_NEXT;
                ST_NEXT: begin
                    if (step_cnt != LAST_STEP)          state_nxt = ST_OBSERVE;
                    else if (episode_cnt != LAST_EPISODE) state_nxt = ST_LOAD;
                    else                                state_nxt = ST_DONE;
                end
                ST_DONE:    if (!start) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        env_load    = (state == ST_LOAD);
        env_step    = (state == ST_STEP);
        state_valid = (state == ST_OBSERVE);
        upd_req     = (state == ST_UPDATE);
        done        = (state == ST_DONE);
        busy        = (state != ST_IDLE);
        learning    = (state != ST_IDLE) && (state != ST_DONE);
    end

    // Datapath: the LFSR free-runs; everything else only moves in its own state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr        <= SEED;
            A           <= 2'd0;
            explore     <= 1'b0;
            reward      <= 6'd0;
            state_out   <= 12'd0;
            step_cnt    <= 8'd0;
            episode_cnt <= 8'd0;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            if (aborting) begin
                step_cnt    <= 8'd0;
                episode_cnt <= 8'd0;
            end else begin
                case (state)
                    ST_OBSERVE: begin
                        state_out <= S;
                        if (act_valid) begin
                            A       <= rand_pick ? lfsr[9:8] : act_in;
                            explore <= rand_pick;
                        end
                    end
                    ST_REWARD: begin
                        reward    <= 6'd0 - queue_sum;
                        state_out <= S;
                    end
                    ST_NEXT: begin
                        if (step_cnt == LAST_STEP) begin
                            step_cnt <= 8'd0;
                            if (episode_cnt != LAST_EPISODE) begin
                                episode_cnt <= episode_cnt + 8'd1;
                            end
                        end else begin
                            step_cnt <= step_cnt + 8'd1;
                        end
                    end
                    ST_DONE: begin
                        if (!start) begin
                            step_cnt    <= 8'd0;
                            episode_cnt <= 8'd0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_episode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_episode_sequencer
//  Description : Directed and random stimulus against a phase-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_episode_sequencer;

    localparam int          NS     = 3;
    localparam int          NE     = 2;
    localparam logic [7:0]  EPS_T  = 8'd64;
    localparam logic [15:0] SEED_T = 16'hACE1;

    localparam int P_IDLE = 0, P_LOAD = 1, P_OBS = 2, P_POST = 3,
                   P_UPD = 4, P_NEXT = 5, P_DONE = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, abort = 1'b0, act_valid = 1'b0, upd_done = 1'b0;
    logic [11:0] S = 12'd0;
    logic [1:0]  act_in = 2'd0;
    logic        env_load, env_step, learning, state_valid, explore, upd_req, busy, done;
    logic [1:0]  A;
    logic [11:0] state_out;
    logic [5:0]  reward;
    logic [7:0]  step_cnt, episode_cnt;

    int vectors = 0;
    int miscompares = 0;

    episode_sequencer #(.N_STEP(NS), .N_EPISODE(NE), .EPS(EPS_T), .SEED(SEED_T)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .S(S),
        .act_valid(act_valid), .act_in(act_in), .upd_done(upd_done),
        .env_load(env_load), .env_step(env_step), .A(A), .learning(learning),
        .state_valid(state_valid), .state_out(state_out), .explore(explore),
        .reward(reward), .upd_req(upd_req), .step_cnt(step_cnt),
        .episode_cnt(episode_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ph, m_k, m_step, m_ep;
    logic [1:0]  m_a;
    logic        m_exp;
    logic [5:0]  m_rew;
    logic [11:0] m_so;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        logic [15:0] bit0;
        bit0 = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
        return (bit0 << 15) | (x >> 1);
    endfunction

    function automatic logic [5:0] penalty(input logic [11:0] s);
        int sum = 0;
        for (int i = 0; i < 4; i++) sum += int'((s >> (3 * i)) & 12'd7);
        return 6'(-sum);
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_k = 0; m_step = 0; m_ep = 0;
        m_a = 2'd0; m_exp = 1'b0; m_rew = 6'd0; m_so = 12'd0; m_lfsr = SEED_T;
    endtask

    task automatic model_advance();
        if (abort && m_ph != P_IDLE) begin
            m_ph = P_IDLE; m_step = 0; m_ep = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (start) m_ph = P_LOAD;
                P_LOAD: m_ph = P_OBS;
                P_OBS: begin
                    m_so = S;
                    if (act_valid) begin
                        m_exp = (m_lfsr[7:0] < EPS_T);
                        m_a   = m_exp ? m_lfsr[9:8] : act_in;
                        m_ph  = P_POST; m_k = 0;
                    end
                end
                P_POST: begin
                    if (m_k == 2) begin
                        m_rew = penalty(S); m_so = S; m_ph = P_UPD;
                    end else m_k++;
                end
                P_UPD: if (upd_done) m_ph = P_NEXT;
                P_NEXT: begin
                    if (m_step == NS - 1) begin
                        m_step = 0;
                        if (m_ep == NE - 1) m_ph = P_DONE;
                        else begin m_ep++; m_ph = P_LOAD; end
                    end else begin
                        m_step++; m_ph = P_OBS;
                    end
                end
                P_DONE: if (!start) begin m_ph = P_IDLE; m_step = 0; m_ep = 0; end
                default: m_ph = P_IDLE;
            endcase
        end
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (!rst) model_reset();
        chk("busy",        busy,        32'(m_ph != P_IDLE));
        chk("done",        done,        32'(m_ph == P_DONE));
        chk("learning",    learning,    32'(m_ph != P_IDLE && m_ph != P_DONE));
        chk("env_load",    env_load,    32'(m_ph == P_LOAD));
        chk("env_step",    env_step,    32'(m_ph == P_POST && m_k == 0));
        chk("state_valid", state_valid, 32'(m_ph == P_OBS));
        chk("upd_req",     upd_req,     32'(m_ph == P_UPD));
        chk("A",           A,           32'(m_a));
        chk("explore",     explore,     32'(m_exp));
        chk("reward",      reward,      32'(m_rew));
        chk("state_out",   state_out,   32'(m_so));
        chk("step_cnt",    step_cnt,    32'(m_step));
        chk("episode_cnt", episode_cnt, 32'(m_ep));
        if (rst) model_advance();
    end

    // ---------------- stimulus ----------------
    task automatic drive_slot();
        @(posedge clk); #2;
    endtask

    task automatic wait_upd();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (upd_req) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL wait_upd_timeout: got no upd_req expected upd_req within 100 cycles");
        end
    endtask

    initial begin
        int  n_step, n_load;
        bit  got_done;
        repeat (3) drive_slot();
        chk("rst_busy", busy, 0);
        chk("rst_A", A, 0);
        chk("rst_reward", reward, 0);
        chk("rst_state_out", state_out, 0);
        rst = 1'b1;
        repeat (3) drive_slot();
        chk("idle_no_start", busy, 0);

        // full run with everything answering immediately
        start = 1'b1; act_valid = 1'b1; upd_done = 1'b1; act_in = 2'd2; S = 12'h123;
        n_step = 0; n_load = 0; got_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (env_step) n_step++;
            if (env_load) n_load++;
            if (done) begin got_done = 1'b1; break; end
        end
        chk("run_done", 32'(got_done), 1);
        chk("run_env_steps", n_step, 6);
        chk("run_env_loads", n_load, 2);
        chk("done_episode", episode_cnt, 8'd1);
        drive_slot(); start = 1'b0;
        drive_slot(); drive_slot();
        chk("done_to_idle", busy, 0);

        // reward corner values
        start = 1'b1; S = 12'hFFF;
        wait_upd();
        chk("reward_full", reward, 6'h24);
        chk("state_out_full", state_out, 12'hFFF);
        drive_slot(); S = 12'h000;
        wait_upd();
        chk("reward_empty", reward, 6'h00);
        drive_slot(); S = 12'h492;
        wait_upd();
        chk("reward_eight", reward, 6'h38);

        // abort collides with upd_done
        drive_slot(); upd_done = 1'b0;
        wait_upd();
        drive_slot(); abort = 1'b1; upd_done = 1'b1; start = 1'b0;
        drive_slot(); abort = 1'b0; upd_done = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_step", step_cnt, 0);
        chk("abort_episode", episode_cnt, 0);

        // asynchronous reset in the middle of UPDATE
        drive_slot(); start = 1'b1;
        wait_upd();
        drive_slot(); rst = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_upd_req", upd_req, 0);
        chk("async_reward", reward, 0);
        chk("async_state_out", state_out, 0);
        start = 1'b0;
        drive_slot(); rst = 1'b1;
        repeat (3) drive_slot();
        chk("post_reset_idle", busy, 0);

        for (int i = 0; i < 4000; i++) begin
            drive_slot();
            start     = ($urandom_range(3) != 0);
            abort     = ($urandom_range(59) == 0);
            act_valid = $urandom_range(1) == 1;
            act_in    = 2'($urandom_range(3));
            upd_done  = ($urandom_range(2) == 0);
            S         = 12'($urandom);
            rst       = ($urandom_range(699) != 0);
        end
        drive_slot(); rst = 1'b1; abort = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
